// File: rtl/bcd_pkg.sv
// Shared definitions for the time-shared binary-to-BCD converter:
// FSM encoding, the blank glyph code and the index-width helper.
package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic [3:0] BCD_BLANK = 4'hF;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bcd_conv_sched_rr_arbiter.sv
// Pointer-based round-robin arbiter: combinational grant of the first request
// at or after the pointer, pointer advanced past the winner on i_adv.
module rr_arbiter
  import bcd_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDW     = idx_w(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_adv,
  input  logic [IDW-1:0]     i_winner,
  output logic               o_any,
  output logic [IDW-1:0]     o_grant_idx
);

  localparam int SW = IDW + 1;

  logic [IDW-1:0] r_ptr;
  logic [SW-1:0]  w_sum;
  logic [IDW-1:0] w_k;

  // Walk offsets from far to near so the closest request to the pointer wins.
  always_comb begin
    o_any       = 1'b0;
    o_grant_idx = '0;
    w_sum       = '0;
    w_k         = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_sum = {1'b0, r_ptr} + SW'(i);
      w_k   = (w_sum >= SW'(NUM_REQ)) ? IDW'(w_sum - SW'(NUM_REQ)) : IDW'(w_sum);
      if (i_req[w_k]) begin
        o_any       = 1'b1;
        o_grant_idx = w_k;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_adv) begin
      r_ptr <= (i_winner == IDW'(NUM_REQ - 1)) ? '0 : i_winner + 1'b1;
    end
  end

endmodule

// File: rtl/bcd_conv_sched.sv
// One shift-add-3 binary-to-BCD engine shared round-robin between NUM_REQ requesters.
// Build option BCD_LEADING_BLANK_EN replaces leading zero digits (except ones) with 4'hF.
module bcd_conv_sched
  import bcd_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int BIT_WIDTH = 8,
  parameter  int NUM_BCD   = 3,
  localparam int IDW       = idx_w(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*BIT_WIDTH-1:0] in,
  output logic [NUM_REQ-1:0]           ack,
  output logic [4*NUM_BCD-1:0]         out,
  output logic [IDW-1:0]               out_id,
  output logic                         out_valid,
  output logic                         ovf,
  output logic                         busy
);

  localparam int CNT_W = idx_w(BIT_WIDTH);
  localparam int ACC_W = 4 * NUM_BCD;

  state_e               r_state, w_state_nxt;
  logic [BIT_WIDTH-1:0] r_bin;
  logic [ACC_W-1:0]     r_acc;
  logic [CNT_W-1:0]     r_cnt;
  logic [IDW-1:0]       r_win;
  logic                 r_ovf_acc;
  logic [ACC_W-1:0]     r_out;
  logic [IDW-1:0]       r_out_id;
  logic                 r_ovf;
  logic                 r_out_valid;
  logic [NUM_REQ-1:0]   r_ack;

  logic                 w_any, w_cap, w_last, w_adv, w_carry;
  logic [IDW-1:0]       w_gidx;
  logic [BIT_WIDTH-1:0] w_op;
  logic [ACC_W-1:0]     w_adj, w_acc_nxt, w_res;

`ifdef BCD_LEADING_BLANK_EN
  function automatic logic [ACC_W-1:0] blank_lead(input logic [ACC_W-1:0] v);
    logic lead;
    lead = 1'b1;
    for (int d = NUM_BCD - 1; d >= 1; d--) begin
      if (lead && (v[4*d +: 4] == 4'd0)) v[4*d +: 4] = BCD_BLANK;
      else                               lead = 1'b0;
    end
    return v;
  endfunction
`endif

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk        (clk),
    .rst        (rst),
    .i_req      (req),
    .i_adv      (w_adv),
    .i_winner   (r_win),
    .o_any      (w_any),
    .o_grant_idx(w_gidx)
  );

  always_comb begin
    w_op = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_gidx == IDW'(k)) w_op = in[k*BIT_WIDTH +: BIT_WIDTH];
    end
  end

  // Add-3 correction, then shift; the top digit's carry drops out into w_carry.
  always_comb begin
    w_adj = r_acc;
    for (int d = 0; d < NUM_BCD; d++) begin
      if (r_acc[4*d +: 4] >= 4'd5) w_adj[4*d +: 4] = r_acc[4*d +: 4] + 4'd3;
    end
    w_acc_nxt = {w_adj[ACC_W-2:0], r_bin[BIT_WIDTH-1]};
    w_carry   = w_adj[ACC_W-1];
`ifdef BCD_LEADING_BLANK_EN
    w_res = blank_lead(w_acc_nxt);
`else
    w_res = w_acc_nxt;
`endif
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cap       = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_state_nxt = ST_SHIFT;
          w_cap       = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (r_cnt == CNT_W'(BIT_WIDTH - 1)) begin
          w_state_nxt = ST_DONE;
          w_last      = 1'b1;
        end
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_adv = (r_state == ST_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Results are registered on the final shift edge so they appear exactly in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_win       <= '0;
      r_ovf_acc   <= 1'b0;
      r_out       <= '0;
      r_out_id    <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_ack       <= '0;
    end else begin
      r_out_valid <= w_last;
      r_ack       <= w_last ? (NUM_REQ'(1) << r_win) : '0;
      if (w_cap) begin
        r_cnt     <= '0;
        r_win     <= w_gidx;
        r_ovf_acc <= 1'b0;
      end else if (r_state == ST_SHIFT) begin
        r_cnt     <= r_cnt + 1'b1;
        r_ovf_acc <= r_ovf_acc | w_carry;
      end
      if (w_last) begin
        r_out    <= w_res;
        r_out_id <= r_win;
        r_ovf    <= r_ovf_acc | w_carry;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_cap) begin
      r_bin <= w_op;
      r_acc <= '0;
    end else if (r_state == ST_SHIFT) begin
      r_bin <= r_bin << 1;
      r_acc <= w_acc_nxt;
    end
  end

  assign ack       = r_ack;
  assign out       = r_out;
  assign out_id    = r_out_id;
  assign out_valid = r_out_valid;
  assign ovf       = r_ovf;
  assign busy      = (r_state != ST_IDLE);

endmodule
